// File: rtl/cambus_gen2.sv
// cambus_gen2 -- camera bus front end, oversampled in the clk domain.
// Recovers pixel strobes, sync pulses, visible-area coordinates, line and
// frame geometry, and a lock flag driven by geometry stability and
// camera-clock presence.
// Ports:
//   clk, rst                  main clock, async active-high reset
//   cam_clk/pixel/hsync/vsync raw camera bus (asynchronous to clk)
//   vid_pixel, vid_pixsync    captured pixel word and its one-cycle strobe
//   vid_hsync, vid_vsync      one-cycle pulses at sync assertion (with strobe)
//   vid_visible               strobe qualifier: no sync active
//   vid_x, vid_y              visible pixel / line index
//   vid_line_len              visible pixels in last completed line
//   vid_frame_lines           visible lines in last completed frame
//   vid_locked                geometry stable and camera clock present
module cambus_gen2 #(
   parameter int PIX_W       = 12,
   parameter int TAPS        = 1,
   parameter int SYNC_LEN    = 2,
   parameter int CLK_EDGE    = 0,
   parameter int HS_POL      = 1,
   parameter int VS_POL      = 1,
   parameter int CNT_W       = 12,
   parameter int LOCK_FRAMES = 2,
   parameter int TIMEOUT     = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cam_clk,
   input  logic [PIX_W*TAPS-1:0] cam_pixel,
   input  logic                  cam_hsync,
   input  logic                  cam_vsync,
   output logic [PIX_W*TAPS-1:0] vid_pixel,
   output logic                  vid_pixsync,
   output logic                  vid_hsync,
   output logic                  vid_vsync,
   output logic                  vid_visible,
   output logic [CNT_W-1:0]      vid_x,
   output logic [CNT_W-1:0]      vid_y,
   output logic [CNT_W-1:0]      vid_line_len,
   output logic [CNT_W-1:0]      vid_frame_lines,
   output logic                  vid_locked
);
   localparam int DW = PIX_W*TAPS;
   localparam int TW = $clog2(TIMEOUT+1);
   localparam int MW = $clog2(LOCK_FRAMES+1);
   localparam logic [CNT_W-1:0] CMAX = '1;

   localparam logic [1:0] S_UNLK  = 2'd0;
   localparam logic [1:0] S_TRAIN = 2'd1;
   localparam logic [1:0] S_LOCK  = 2'd2;

   // synchroniser chains; clk_q is the previous value of the chain output
   logic [SYNC_LEN-1:0]          clk_sr, hs_sr, vs_sr;
   logic [SYNC_LEN-1:0][DW-1:0]  pix_sr;
   logic                         clk_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sr <= '0;
         hs_sr  <= '0;
         vs_sr  <= '0;
         pix_sr <= '0;
         clk_q  <= 1'b0;
      end else begin
         clk_sr <= {clk_sr[SYNC_LEN-2:0], cam_clk};
         hs_sr  <= {hs_sr[SYNC_LEN-2:0], cam_hsync};
         vs_sr  <= {vs_sr[SYNC_LEN-2:0], cam_vsync};
         pix_sr <= {pix_sr[SYNC_LEN-2:0], cam_pixel};
         clk_q  <= clk_sr[SYNC_LEN-1];
      end
   end

   logic clk_s, cam_edge, hs_a, vs_a, vis, hs_prev, vs_prev, hs_rise, vs_rise;
   assign clk_s    = clk_sr[SYNC_LEN-1];
   assign cam_edge = (CLK_EDGE == 0) ? (clk_s & ~clk_q) : (~clk_s & clk_q);
   assign hs_a     = (hs_sr[SYNC_LEN-1] == 1'(HS_POL));
   assign vs_a     = (vs_sr[SYNC_LEN-1] == 1'(VS_POL));
   assign vis      = ~(hs_a | vs_a);
   assign hs_rise  = hs_a & ~hs_prev;
   assign vs_rise  = vs_a & ~vs_prev;

   // camera-clock watchdog
   logic [TW-1:0] to_cnt;
   logic          timed_out;
   assign timed_out = (to_cnt == TW'(TIMEOUT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            to_cnt <= '0;
      else if (cam_edge)  to_cnt <= '0;
      else if (!timed_out) to_cnt <= to_cnt + TW'(1);
   end

   // geometry counters; *_ovf marks a count that ran past CMAX
   logic [CNT_W-1:0] x_cnt, y_cnt, y_n;
   logic             x_ovf, y_ovf, y_ovf_n, line_sat, frame_sat;

   // y after the line ending on this strobe, so a simultaneous vsync sees it
   always_comb begin
      y_n     = y_cnt;
      y_ovf_n = y_ovf;
      if (hs_rise && (x_cnt != '0)) begin
         if (y_cnt == CMAX) y_ovf_n = 1'b1;
         else               y_n     = y_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vid_pixel       <= '0;
         vid_pixsync     <= 1'b0;
         vid_hsync       <= 1'b0;
         vid_vsync       <= 1'b0;
         vid_visible     <= 1'b0;
         vid_x           <= '0;
         vid_y           <= '0;
         vid_line_len    <= '0;
         vid_frame_lines <= '0;
         line_sat        <= 1'b0;
         frame_sat       <= 1'b0;
         hs_prev         <= 1'b0;
         vs_prev         <= 1'b0;
         x_cnt           <= '0;
         y_cnt           <= '0;
         x_ovf           <= 1'b0;
         y_ovf           <= 1'b0;
      end else begin
         vid_pixsync <= cam_edge;
         vid_hsync   <= cam_edge & hs_rise;
         vid_vsync   <= cam_edge & vs_rise;
         if (cam_edge) begin
            vid_pixel   <= pix_sr[SYNC_LEN-1];
            vid_visible <= vis;
            hs_prev     <= hs_a;
            vs_prev     <= vs_a;
            if (vis) begin
               vid_x <= x_cnt;
               vid_y <= y_cnt;
               if (x_cnt == CMAX) x_ovf <= 1'b1;
               else               x_cnt <= x_cnt + 1'b1;
            end
            if (hs_rise) begin
               vid_line_len <= x_cnt;
               line_sat     <= x_ovf;
               x_cnt        <= '0;
               x_ovf        <= 1'b0;
               y_cnt        <= y_n;
               y_ovf        <= y_ovf_n;
            end
            if (vs_rise) begin
               vid_frame_lines <= y_n;
               frame_sat       <= y_ovf_n;
               x_cnt           <= '0;
               x_ovf           <= 1'b0;
               y_cnt           <= '0;
               y_ovf           <= 1'b0;
            end
         end else if (timed_out) begin
            x_cnt <= '0;
            y_cnt <= '0;
            x_ovf <= 1'b0;
            y_ovf <= 1'b0;
         end
      end
   end

   // lock FSM works from the registered pulses, so it reacts one cycle
   // after the corresponding vid_hsync / vid_vsync
   logic [1:0]       state;
   logic [MW-1:0]    match_cnt;
   logic [CNT_W-1:0] ref_len, ref_lines;
   logic             ref_len_v, ref_lines_v, line_ev, line_bad;

   assign line_ev    = vid_hsync && (vid_line_len != '0);
   assign line_bad   = line_sat || (ref_len_v && (vid_line_len != ref_len));
   assign vid_locked = (state == S_LOCK);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_UNLK;
         match_cnt   <= '0;
         ref_len     <= '0;
         ref_lines   <= '0;
         ref_len_v   <= 1'b0;
         ref_lines_v <= 1'b0;
      end else if (timed_out) begin
         state <= S_UNLK;
      end else begin
         case (state)
            S_UNLK: if (vid_vsync) begin
               state       <= S_TRAIN;
               match_cnt   <= '0;
               ref_len_v   <= 1'b0;
               ref_lines_v <= 1'b0;
            end
            S_TRAIN: begin
               if (line_ev && line_bad) begin
                  state <= S_UNLK;
               end else begin
                  if (line_ev && !ref_len_v) begin
                     ref_len   <= vid_line_len;
                     ref_len_v <= 1'b1;
                  end
                  if (vid_vsync) begin
                     ref_lines   <= vid_frame_lines;
                     ref_lines_v <= 1'b1;
                     if ((vid_frame_lines == '0) || frame_sat) begin
                        state <= S_UNLK;
                     end else if (!ref_lines_v || (vid_frame_lines == ref_lines)) begin
                        match_cnt <= match_cnt + MW'(1);
                        if (int'(match_cnt) + 1 >= LOCK_FRAMES) state <= S_LOCK;
                     end else begin
                        match_cnt <= MW'(1);
                        if (LOCK_FRAMES == 1) state <= S_LOCK;
                     end
                  end
               end
            end
            S_LOCK: begin
               if (line_ev && (line_sat || (vid_line_len != ref_len)))
                  state <= S_UNLK;
               else if (vid_vsync && (frame_sat || (vid_frame_lines != ref_lines)))
                  state <= S_UNLK;
            end
            default: state <= S_UNLK;
         endcase
      end
   end
endmodule
